spi_rx_arbiter: RTL and testbench
=================================

Name: spi_rx_arbiter

Overview:
- Shares one `spi_rx` byte receiver between two requesters; each requester reads a burst of bytes from its own SPI slave.
- Per burst: arbitrates round-robin, drives the winner's chip select, issues per-byte `rd_en` pulses to `spi_rx` and forwards each received byte tagged with its destination.
- Generates the `spi_rx` bit-rate `clk_en` strobe.
- Sits between the requesting logic and the `spi_rx` instance.

Parameters:
- `CLK_DIV`, 4: `rx_clk_en` period in `clk` cycles; legal range 2..255.
- `LEN_W`, 8: width of the burst length inputs.
- `CS_SETUP`, 2: `clk` cycles from `cs_n` assertion to the first `rx_rd_en`; legal range 1..15.
- `CS_HOLD`, 2: `clk` cycles from the last byte received to `cs_n` deassertion; legal range 1..15.

Ports:
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, 2: per-requester level request.
- `len0`, in, `LEN_W`: burst length for requester 0, in bytes.
- `len1`, in, `LEN_W`: burst length for requester 1, in bytes.
- `gnt`, out, 2: one-hot grant, high for the whole burst.
- `done`, out, 2: one-cycle pulse per requester at burst end.
- `byte_valid`, out, 1: one-cycle pulse, received byte available.
- `byte_data`, out, 8: received byte; valid while `byte_valid`=1.
- `byte_dst`, out, 1: index of the requester that owns `byte_data`.
- `cs_n`, out, 2: active-low chip selects.
- `rx_rd_en`, out, 1: to `spi_rx` `rd_en`.
- `rx_data`, in, 8: from `spi_rx` `data_out`.
- `rx_received`, in, 1: from `spi_rx` `received`.
- `rx_clk_en`, out, 1: to `spi_rx` `clk_en`.

Behaviour:
- Reset (asynchronous, `rst_n`=0):
  - State goes to INIT. `gnt`, `done`, `byte_valid`, `rx_rd_en`, `rx_clk_en` = 0; `byte_data`, `byte_dst` = 0; `cs_n` = 2'b11.
  - Divider counter = 0; `last` = 1, so requester 0 wins the first tie.
- Divider:
  - Free-runs in every state after reset.
  - `rx_clk_en` = 1 for one cycle when the counter reaches `CLK_DIV`-1, then the counter wraps to 0.
  - First pulse occurs at cycle `CLK_DIV` after reset release.
- INIT:
  - Waits 10*`CLK_DIV` cycles so that a byte left in flight in `spi_rx` (which has no reset) completes.
  - `rx_received` is ignored; then goes to IDLE.
- IDLE:
  - If exactly one `req` bit is high, grant it. If both are high, grant `!last`.
  - On grant: set `gnt[i]`, `cs_n[i]`=0, latch `len_i` into `remaining`, set `last`=i, go to SETUP.
- SETUP:
  - Counts `CS_SETUP` cycles.
  - If `remaining`==0, go to HOLD; otherwise go to READ.
- READ:
  - `rx_rd_en`=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On `rx_received`=1: on the next cycle `byte_valid`=1, `byte_data`=`rx_data` (sampled in the `rx_received` cycle), `byte_dst`=i.
  - Same edge: `remaining` -= 1. Go to HOLD if the result is 0, else READ.
  - Consecutive `rx_rd_en` pulses are therefore at least 2 cycles apart.
- HOLD:
  - Counts `CS_HOLD` cycles with `cs_n[i]` still 0.
  - Then `cs_n` = 2'b11, `gnt` = 0, `done[i]` = 1 for one cycle, and go to GAP.
- GAP:
  - Lasts exactly 1 cycle; guarantees `cs_n` is high for at least 2 cycles between bursts. Then go to IDLE.
- Request/grant rules:
  - `req` and `len` are sampled only in IDLE. Dropping `req` mid-burst does not abort the burst.
  - `req` still high after `done` is a new request.
- `rx_received` outside WAIT is ignored and produces no `byte_valid`.
- At most one `cs_n` bit is low at any time. `gnt` and `cs_n` are never both asserted for different requesters.
- `len`=2^`LEN_W`-1 (255) is a legal burst length; `remaining` is `LEN_W` bits wide.
- Reset asserted mid-burst: all outputs drop immediately (asynchronously); no `done` pulse is generated; INIT is re-entered.

Test Plan:
1. Reset release, `req`=2'b01 at cycle 5, `len0`=3, `CLK_DIV`=4:
   - No `gnt` before cycle 40 (INIT).
   - Then `cs_n`=2'b10 and exactly 3 `rx_rd_en` pulses; with a behavioural `spi_rx` model returning 0xA5, 0x3C, 0xFF, `byte_valid` fires 3 times with those values and `byte_dst`=0.
   - `done`=2'b01 pulses once, 2 cycles after the third byte.
2. `req`=2'b11 held high, `len0`=`len1`=1:
   - Grants alternate 0,1,0,1 over 4 bursts.
   - `cs_n` is high for at least 2 cycles between bursts and is never 2'b00.
3. `len1`=0, `req`=2'b10:
   - `cs_n[1]` low for `CS_SETUP`+`CS_HOLD`=4 cycles.
   - No `rx_rd_en`, no `byte_valid`, one `done[1]` pulse.
4. `len0`=255:
   - Exactly 255 `byte_valid` pulses, then one `done[0]`.
   - `req[0]` dropped after the 10th byte: the burst still completes.
5. Assert `rst_n`=0 during the 2nd byte of a `len0`=4 burst:
   - `cs_n`=2'b11 and `gnt`=0 asynchronously.
   - Model `spi_rx` finishes its byte and pulses `received` during INIT: no `byte_valid` appears.
   - The next burst returns correct data.
6. Inject a spurious `rx_received` pulse in IDLE and in SETUP:
   - No `byte_valid`; state sequence is unaffected.

Source files
------------

// File: rtl/spi_rx_arbiter_if.sv
// Requester-side and spi_rx-side signals of the shared SPI byte receiver arbiter.
interface spi_rx_arbiter_if #(
  parameter int unsigned LEN_W = 8
) ();
  logic [1:0]       req;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_dst;
  logic [1:0]       cs_n;
  logic             rx_rd_en;
  logic [7:0]       rx_data;
  logic             rx_received;
  logic             rx_clk_en;

  // Arbiter side
  modport slave (
    input  req, len0, len1, rx_data, rx_received,
    output gnt, done, byte_valid, byte_data, byte_dst, cs_n, rx_rd_en, rx_clk_en
  );

  // Requesters plus spi_rx side
  modport master (
    output req, len0, len1, rx_data, rx_received,
    input  gnt, done, byte_valid, byte_data, byte_dst, cs_n, rx_rd_en, rx_clk_en
  );
endinterface

// File: rtl/spi_rx_arbiter.sv
// Round-robin sharing of one spi_rx byte receiver between two burst requesters.
module spi_rx_arbiter #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned LEN_W    = 8,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input logic             clk,
  input logic             rst_n,
  spi_rx_arbiter_if.slave bus
);

  localparam int unsigned DIV_W    = 8;
  localparam int unsigned TMR_W    = 12;
  localparam int unsigned INIT_CYC = 10 * CLK_DIV;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_READ,
    S_WAIT,
    S_HOLD,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             clk_en_q, clk_en_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       cs_n_q, cs_n_d;
  logic             rd_en_q, rd_en_d;
  logic             bv_q, bv_d;
  logic [7:0]       data_q, data_d;
  logic             dst_q, dst_d;
  logic             win;

  // Free-running bit-rate strobe for spi_rx
  always_comb begin
    clk_en_d = (div_q == DIV_W'(CLK_DIV - 1));
    div_d    = clk_en_d ? '0 : DIV_W'(div_q + DIV_W'(1));
  end

  // Burst sequencing: next state and next registered outputs
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rem_d   = rem_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cs_n_d  = cs_n_q;
    done_d  = 2'b00;
    rd_en_d = 1'b0;
    bv_d    = 1'b0;
    data_d  = data_q;
    dst_d   = dst_q;
    win     = 1'b0;

    case (state_q)
      S_INIT: begin
        // Let any byte spi_rx had in flight drain before trusting it
        if (tmr_q == TMR_W'(INIT_CYC - 1)) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = TMR_W'(tmr_q + TMR_W'(1));
        end
      end
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          win     = (bus.req == 2'b11) ? ~last_q : bus.req[1];
          sel_d   = win;
          last_d  = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          cs_n_d  = win ? 2'b01 : 2'b10;
          rem_d   = win ? bus.len1 : bus.len0;
          tmr_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (tmr_q == TMR_W'(CS_SETUP - 1)) begin
          tmr_d = '0;
          if (rem_q == '0) begin
            state_d = S_HOLD;
          end else begin
            rd_en_d = 1'b1;
            state_d = S_READ;
          end
        end else begin
          tmr_d = TMR_W'(tmr_q + TMR_W'(1));
        end
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.rx_received) begin
          bv_d   = 1'b1;
          data_d = bus.rx_data;
          dst_d  = sel_q;
          rem_d  = LEN_W'(rem_q - LEN_W'(1));
          tmr_d  = '0;
          if (rem_q == LEN_W'(1)) begin
            state_d = S_HOLD;
          end else begin
            rd_en_d = 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_HOLD: begin
        if (tmr_q == TMR_W'(CS_HOLD - 1)) begin
          tmr_d   = '0;
          cs_n_d  = 2'b11;
          gnt_d   = 2'b00;
          done_d  = sel_q ? 2'b10 : 2'b01;
          state_d = S_GAP;
        end else begin
          tmr_d = TMR_W'(tmr_q + TMR_W'(1));
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      div_q    <= '0;
      clk_en_q <= 1'b0;
      tmr_q    <= '0;
      rem_q    <= '0;
      last_q   <= 1'b1;
      sel_q    <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      cs_n_q   <= 2'b11;
      rd_en_q  <= 1'b0;
      bv_q     <= 1'b0;
      data_q   <= '0;
      dst_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      clk_en_q <= clk_en_d;
      tmr_q    <= tmr_d;
      rem_q    <= rem_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      cs_n_q   <= cs_n_d;
      rd_en_q  <= rd_en_d;
      bv_q     <= bv_d;
      data_q   <= data_d;
      dst_q    <= dst_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.cs_n       = cs_n_q;
  assign bus.rx_rd_en   = rd_en_q;
  assign bus.rx_clk_en  = clk_en_q;
  assign bus.byte_valid = bv_q;
  assign bus.byte_data  = data_q;
  assign bus.byte_dst   = dst_q;

endmodule

// File: tb/tb_spi_rx_arbiter.sv
// Bench for spi_rx_arbiter: table of bursts, hand-written corner sequences, random bursts.
module tb_spi_rx_arbiter;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int          BUD      = 20000;

  typedef struct packed {
    logic [7:0] data;
    logic       dst;
  } exp_t;

  typedef struct {
    logic [1:0] req;
    int         len0;
    int         len1;
    int         dst;
    int         nbytes;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic spur_rcv = 1'b0;
  logic m_rcv = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic m_busy = 1'b0;
  logic [3:0] m_bits = 4'd0;
  int rcv_cnt = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int rr_last = 1;
  int last_gnt_cyc = 0;
  int last_rd = -100;
  int last_ce = -1;
  int hi_run = 0;
  exp_t exp_q[$];
  logic [7:0] tx_q[$];

  spi_rx_arbiter_if #(.LEN_W(LEN_W)) bus ();

  spi_rx_arbiter #(
    .CLK_DIV (CLK_DIV),
    .LEN_W   (LEN_W),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.rx_received = m_rcv | spur_rcv;
  assign bus.rx_data     = m_data;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Behavioural spi_rx: 8 bit strobes per byte, no reset; the slave behind the low cs_n supplies data
  always @(posedge clk) begin : spi_model
    logic [7:0] nb;
    exp_t e;
    m_rcv <= 1'b0;
    if (m_busy) begin
      if (bus.rx_clk_en) begin
        if (m_bits == 4'd7) begin
          m_rcv   <= 1'b1;
          m_busy  <= 1'b0;
          rcv_cnt <= rcv_cnt + 1;
        end
        m_bits <= m_bits + 4'd1;
      end
    end else if (bus.rx_rd_en) begin
      nb = (tx_q.size() != 0) ? tx_q.pop_front() : 8'($urandom);
      e.data = nb;
      e.dst  = bus.cs_n[0];
      exp_q.push_back(e);
      m_data <= nb;
      m_busy <= 1'b1;
      m_bits <= 4'd0;
    end
  end

  // Continuous protocol monitor and received-byte scoreboard
  always @(negedge clk) begin : monitor
    logic [1:0] inv_cs;
    exp_t e;
    if (!rst_n) begin
      last_rd = -100;
      last_ce = -1;
      hi_run  = 0;
    end else begin
      inv_cs = ~bus.cs_n;
      check("cs_not_both_low", 32'(bus.cs_n != 2'b00), 32'd1);
      check("gnt_matches_cs", 32'(bus.gnt), 32'(inv_cs));
      if (bus.cs_n == 2'b11) begin
        hi_run++;
      end else begin
        if (hi_run > 0) check("cs_high_gap", 32'(hi_run >= 2), 32'd1);
        hi_run = 0;
      end
      if (bus.byte_valid) begin
        check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("byte_data", 32'(bus.byte_data), 32'(e.data));
          check("byte_dst", 32'(bus.byte_dst), 32'(e.dst));
        end
      end
      if (bus.rx_rd_en) begin
        check("rd_en_spacing", 32'(cyc - last_rd >= 2), 32'd1);
        last_rd = cyc;
      end
      if (bus.rx_clk_en) begin
        if (last_ce >= 0) check("clk_en_period", 32'(cyc - last_ce), 32'(CLK_DIV));
        last_ce = cyc;
      end
    end
  end

  // One burst: wait for grant, follow it to done, check counts and timing
  task automatic run_burst(input string tag, input logic [1:0] r, input int l0, input int l1,
                           input int exp_dst, input int exp_bytes, input int drop_after,
                           input bit spur_setup);
    int n, bv, rd, cslow, lastbv, done_cyc;
    bit seen;
    bus.req  = r;
    bus.len0 = LEN_W'(l0);
    bus.len1 = LEN_W'(l1);
    n = 0;
    seen = 0;
    while (!seen && n < BUD) begin
      @(negedge clk);
      n++;
      if (bus.gnt != 2'b00) seen = 1;
    end
    check({tag, " gnt"}, 32'(bus.gnt), 32'(1 << exp_dst));
    if (!seen) return;
    last_gnt_cyc = cyc;
    bv = 0; rd = 0; cslow = 0; lastbv = 0; n = 0; seen = 0;
    do begin
      if (spur_setup) spur_rcv = (n == 0);
      if (bus.cs_n[exp_dst] == 1'b0) cslow++;
      if (bus.rx_rd_en) rd++;
      if (bus.byte_valid) begin
        bv++;
        lastbv = cyc;
        if (bv == drop_after) bus.req = 2'b00;
      end
      if (bus.done != 2'b00) begin
        seen = 1;
      end else begin
        @(negedge clk);
        n++;
      end
    end while (!seen && n < BUD);
    spur_rcv = 1'b0;
    done_cyc = cyc;
    check({tag, " done"}, 32'(bus.done), 32'(1 << exp_dst));
    check({tag, " bytes"}, 32'(bv), 32'(exp_bytes));
    check({tag, " rd_en"}, 32'(rd), 32'(exp_bytes));
    if (exp_bytes == 0) check({tag, " cs_low"}, 32'(cslow), 32'(CS_SETUP + CS_HOLD));
    else                check({tag, " done_lat"}, 32'(done_cyc - lastbv), 32'(CS_HOLD));
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
    rr_last = exp_dst;
  endtask

  initial begin : main
    vec_t vecs[8];
    int n, bvw, rc0, first_ce;

    vecs[0] = '{req: 2'b01, len0: 3, len1: 0, dst: 0, nbytes: 3};
    vecs[1] = '{req: 2'b11, len0: 1, len1: 1, dst: 1, nbytes: 1};
    vecs[2] = '{req: 2'b11, len0: 1, len1: 1, dst: 0, nbytes: 1};
    vecs[3] = '{req: 2'b11, len0: 1, len1: 1, dst: 1, nbytes: 1};
    vecs[4] = '{req: 2'b11, len0: 1, len1: 1, dst: 0, nbytes: 1};
    vecs[5] = '{req: 2'b10, len0: 0, len1: 0, dst: 1, nbytes: 0};
    vecs[6] = '{req: 2'b01, len0: 2, len1: 5, dst: 0, nbytes: 2};
    vecs[7] = '{req: 2'b10, len0: 2, len1: 5, dst: 1, nbytes: 5};

    bus.req  = 2'b00;
    bus.len0 = '0;
    bus.len1 = '0;
    #1 rst_n = 1'b0;
    #3;
    check("rst gnt", 32'(bus.gnt), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst cs_n", 32'(bus.cs_n), 32'd3);
    check("rst byte_valid", 32'(bus.byte_valid), 32'd0);
    check("rst byte_data", 32'(bus.byte_data), 32'd0);
    check("rst byte_dst", 32'(bus.byte_dst), 32'd0);
    check("rst rd_en", 32'(bus.rx_rd_en), 32'd0);
    check("rst clk_en", 32'(bus.rx_clk_en), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // First strobe lands CLK_DIV cycles after release
    first_ce = -1;
    repeat (5) begin
      @(negedge clk);
      if (bus.rx_clk_en && first_ce < 0) first_ce = cyc;
    end
    check("first clk_en", 32'(first_ce), 32'(CLK_DIV));

    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'hFF);
    for (int i = 0; i < 8; i++) begin
      run_burst($sformatf("vec%0d", i), vecs[i].req, vecs[i].len0, vecs[i].len1,
                vecs[i].dst, vecs[i].nbytes, -1, 1'b0);
      if (i == 0) check("first gnt cycle", 32'(last_gnt_cyc), 32'(10 * CLK_DIV + 1));
    end

    // Longest burst, request withdrawn part way through
    run_burst("len255", 2'b01, 255, 0, 0, 255, 10, 1'b0);

    // Reset in the middle of the second byte of a 4-byte burst
    bus.req  = 2'b01;
    bus.len0 = LEN_W'(4);
    n = 0; bvw = 0;
    while (bvw < 1 && n < BUD) begin
      @(negedge clk);
      n++;
      if (bus.byte_valid) bvw++;
    end
    while (!bus.rx_rd_en && n < BUD) begin
      @(negedge clk);
      n++;
    end
    check("rst_burst reached byte 2", 32'(bus.rx_rd_en), 32'd1);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async cs_n", 32'(bus.cs_n), 32'd3);
    check("async gnt", 32'(bus.gnt), 32'd0);
    check("async done", 32'(bus.done), 32'd0);
    exp_q.delete();
    bus.req = 2'b00;
    rr_last = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rc0 = rcv_cnt;
    bvw = 0;
    repeat (10 * CLK_DIV - 2) begin
      @(negedge clk);
      if (bus.byte_valid || bus.done != 2'b00) bvw++;
    end
    check("init stale received", 32'(rcv_cnt - rc0), 32'd1);
    check("init no byte_valid", 32'(bvw), 32'd0);
    run_burst("after_rst", 2'b11, 2, 2, 0, 2, -1, 1'b0);

    // Spurious received pulse while idle, then during setup
    bus.req  = 2'b00;
    spur_rcv = 1'b1;
    @(negedge clk);
    spur_rcv = 1'b0;
    bvw = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.byte_valid || bus.gnt != 2'b00) bvw++;
    end
    check("idle spurious", 32'(bvw), 32'd0);
    run_burst("setup_spur", 2'b10, 1, 3, 1, 3, -1, 1'b1);

    // Random bursts against the round-robin reference
    for (int i = 0; i < 16; i++) begin
      logic [1:0] r;
      int a, b, d;
      r = 2'($urandom_range(1, 3));
      a = int'($urandom_range(0, 5));
      b = int'($urandom_range(0, 5));
      if (r == 2'b01)      d = 0;
      else if (r == 2'b10) d = 1;
      else                 d = (rr_last == 1) ? 0 : 1;
      run_burst($sformatf("rand%0d", i), r, a, b, d, (d == 0) ? a : b, -1, 1'b0);
    end

    bus.req = 2'b00;
    repeat (5) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
